// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control unit: FSM state encodings,
// opcode / opext / R-type function codes, ALUOp_* encodings and the
// instruction classes produced by the decoder.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        HALT   = 3'd4
    } cpuState_t;

    // Primary opcodes, IR[15:12]
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_LDST  = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_BEQ   = 4'hC;
    localparam logic [3:0] OP_MOVI  = 4'hD;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Opext codes for OP_LDST, IR[7:4]
    localparam logic [3:0] EXT_LOAD = 4'h0;
    localparam logic [3:0] EXT_STOR = 4'h4;

    // R-type function codes, IR[7:4]
    localparam logic [3:0] FN_AND = 4'h1;
    localparam logic [3:0] FN_OR  = 4'h2;
    localparam logic [3:0] FN_XOR = 4'h3;
    localparam logic [3:0] FN_ADD = 4'h5;
    localparam logic [3:0] FN_SUB = 4'h9;
    localparam logic [3:0] FN_CMP = 4'hB;
    localparam logic [3:0] FN_MOV = 4'hD;

    // ALU operation codes shared with reg_alu
    localparam logic [4:0] ALUOp_NOP = 5'd0;
    localparam logic [4:0] ALUOp_ADD = 5'd1;
    localparam logic [4:0] ALUOp_SUB = 5'd2;
    localparam logic [4:0] ALUOp_AND = 5'd3;
    localparam logic [4:0] ALUOp_OR  = 5'd4;
    localparam logic [4:0] ALUOp_XOR = 5'd5;
    localparam logic [4:0] ALUOp_MOV = 5'd6;
    localparam logic [4:0] ALUOp_CMP = 5'd7;

    // Position of the Z flag inside {C,L,F,Z,N}
    localparam int PSR_Z = 1;

    typedef enum logic [2:0] {
        IC_NOP  = 3'd0,
        IC_ALU  = 3'd1,
        IC_CMP  = 3'd2,
        IC_LOAD = 3'd3,
        IC_STOR = 3'd4,
        IC_BEQ  = 3'd5,
        IC_HALT = 3'd6
    } instrClass_t;

    // R-type function field to ALU operation; unknown codes become NOP
    function automatic logic [4:0] funcToAluOp(input logic [3:0] fn);
        case (fn)
            FN_ADD:  return ALUOp_ADD;
            FN_SUB:  return ALUOp_SUB;
            FN_AND:  return ALUOp_AND;
            FN_OR:   return ALUOp_OR;
            FN_XOR:  return ALUOp_XOR;
            FN_MOV:  return ALUOp_MOV;
            FN_CMP:  return ALUOp_CMP;
            default: return ALUOp_NOP;
        endcase
    endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder.
//   ir      in  16  instruction register
//   aluOp   out 5   ALU operation (ALUOp_*)
//   imm     out 16  extended immediate / branch displacement
//   immMux  out 1   1 = ALU B operand comes from imm
//   iClass  out 3   instruction class steering the control FSM
module cpu_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [15:0]  ir,
    output logic [4:0]   aluOp,
    output logic [15:0]  imm,
    output logic         immMux,
    output instrClass_t  iClass
);

    always_comb begin
        aluOp  = ALUOp_NOP;
        imm    = '0;
        immMux = 1'b0;
        iClass = IC_NOP;
        case (ir[15:12])
            OP_RTYPE: begin
                aluOp = funcToAluOp(ir[7:4]);
                if (aluOp == ALUOp_CMP) begin
                    iClass = IC_CMP;
                end else if (aluOp != ALUOp_NOP) begin
                    iClass = IC_ALU;
                end
            end
            OP_ADDI: begin
                aluOp  = ALUOp_ADD;
                immMux = 1'b1;
                imm    = {{8{ir[7]}}, ir[7:0]};
                iClass = IC_ALU;
            end
            OP_MOVI: begin
                aluOp  = ALUOp_MOV;
                immMux = 1'b1;
                imm    = {8'h00, ir[7:0]};
                iClass = IC_ALU;
            end
            OP_LDST: begin
                if (ir[7:4] == EXT_LOAD) begin
                    iClass = IC_LOAD;
                end else if (ir[7:4] == EXT_STOR) begin
                    iClass = IC_STOR;
                end
            end
            OP_BEQ: begin
                // Displacement travels on imm; it only feeds the PC adder
                imm    = {{8{ir[7]}}, ir[7:0]};
                iClass = IC_BEQ;
            end
            OP_HALT: begin
                iClass = IC_HALT;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle CPU control unit: FETCH -> DECODE -> EXEC [-> MEM] -> FETCH,
// plus a terminal HALT state left only by reset.
//   clk, reset          clock, synchronous active-high reset
//   mem_req/we/addr     memory request handshake (held until mem_ack)
//   mem_ack, mem_rdata  memory completion and read data
//   pc                  program counter
//   rSrc, rDst          register-file selects
//   aluOp, imm, IMM_MUX ALU control from the decoder
//   write, wb_mem       register write strobe and writeback source
//   psr_we              flag register update strobe
//   dSrc, dDst          register read data (load/store address, store data)
//   psrIn               flags {C,L,F,Z,N}
//   halted              HALT instruction has executed
module cpu_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] pc,
    output logic [3:0]  rSrc,
    output logic [3:0]  rDst,
    output logic [4:0]  aluOp,
    output logic [15:0] imm,
    output logic        IMM_MUX,
    output logic        write,
    output logic        wb_mem,
    output logic        psr_we,
    input  logic [15:0] dSrc,
    input  logic [15:0] dDst,
    input  logic [4:0]  psrIn,
    output logic        halted
);

    cpuState_t   stateReg, stateNext;
    logic [15:0] pcReg, pcNext;
    logic [15:0] irReg, irNext;
    logic [15:0] pcInc;

    logic [4:0]  decAluOp;
    logic [15:0] decImm;
    logic        decImmMux;
    instrClass_t decClass;
    logic        decActive;

    // Store data is routed by the datapath; only Z steers branches
    logic        unusedInputs;
    assign unusedInputs = ^{dDst, psrIn[4:2], psrIn[0]};

    cpu_decode uDecode (
        .ir     (irReg),
        .aluOp  (decAluOp),
        .imm    (decImm),
        .immMux (decImmMux),
        .iClass (decClass)
    );

    assign pcInc = pcReg + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= FETCH;
            pcReg    <= '0;
            irReg    <= '0;
        end else begin
            stateReg <= stateNext;
            pcReg    <= pcNext;
            irReg    <= irNext;
        end
    end

    // Strobes are combinational from state and mem_ack so a zero-wait ack
    // completes in the cycle it arrives. Everything is forced low while
    // reset is high, which also discards any ack arriving in that window.
    always_comb begin
        stateNext = stateReg;
        pcNext    = pcReg;
        irNext    = irReg;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        write     = 1'b0;
        psr_we    = 1'b0;
        wb_mem    = 1'b0;
        if (!reset) begin
            case (stateReg)
                FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pcReg;
                    if (mem_ack) begin
                        irNext    = mem_rdata;
                        stateNext = DECODE;
                    end
                end
                DECODE: begin
                    stateNext = EXEC;
                end
                EXEC: begin
                    stateNext = FETCH;
                    pcNext    = pcInc;
                    case (decClass)
                        IC_ALU: begin
                            write  = 1'b1;
                            psr_we = 1'b1;
                        end
                        IC_CMP: begin
                            psr_we = 1'b1;
                        end
                        IC_LOAD, IC_STOR: begin
                            stateNext = MEM;
                            pcNext    = pcReg;
                        end
                        IC_BEQ: begin
                            if (psrIn[PSR_Z]) begin
                                pcNext = pcReg + decImm;
                            end
                        end
                        IC_HALT: begin
                            stateNext = HALT;
                            pcNext    = pcReg;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    mem_req  = 1'b1;
                    mem_addr = dSrc;
                    mem_we   = (decClass == IC_STOR);
                    if (mem_ack) begin
                        write     = (decClass == IC_LOAD);
                        wb_mem    = (decClass == IC_LOAD);
                        pcNext    = pcInc;
                        stateNext = FETCH;
                    end
                end
                HALT: ;
                default: begin
                    stateNext = FETCH;
                end
            endcase
        end
    end

    // Decode fields are only presented while an instruction is in flight
    assign decActive = !reset && (stateReg == DECODE || stateReg == EXEC || stateReg == MEM);
    assign rDst      = decActive ? irReg[11:8] : 4'd0;
    assign rSrc      = decActive ? irReg[3:0]  : 4'd0;
    assign aluOp     = decActive ? decAluOp    : ALUOp_NOP;
    assign imm       = decActive ? decImm      : 16'd0;
    assign IMM_MUX   = decActive ? decImmMux   : 1'b0;

    assign pc     = pcReg;
    assign halted = !reset && (stateReg == HALT);

endmodule

// File: tb/tb_cpu_ctrl.sv
module tb_cpu_ctrl;
    import cpu_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_rdata, pc, imm, dSrc, dDst;
    logic [3:0]  rSrc, rDst;
    logic [4:0]  aluOp, psrIn;
    logic        IMM_MUX, write, wb_mem, psr_we, halted;

    cpu_ctrl dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pc(pc), .rSrc(rSrc), .rDst(rDst), .aluOp(aluOp), .imm(imm),
        .IMM_MUX(IMM_MUX), .write(write), .wb_mem(wb_mem), .psr_we(psr_we),
        .dSrc(dSrc), .dDst(dDst), .psrIn(psrIn), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ir;
        logic        z;
        logic [15:0] dsrc;
        int          fWait;
        int          mWait;
        bit          isMem;
        bit          isAlu;
        logic [3:0]  eRDst;
        logic [3:0]  eRSrc;
        logic [4:0]  eAluOp;
        logic [15:0] eImm;
        logic        eMux;
        int          eWrites;
        int          ePsr;
        logic        eWb;
        logic        eMemWe;
        logic [15:0] ePcNext;
        int          eLat;
    } vec_t;

    int          testsRun  = 0;
    int          failCount = 0;
    logic [15:0] expPc     = 16'h0000;
    vec_t        sbq[$];
    vec_t        vecs[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] ir, input logic z, input logic [15:0] dsrc,
                                input int fWait, input int mWait, input bit isMem, input bit isAlu,
                                input logic [3:0] rd, input logic [3:0] rs, input logic [4:0] op,
                                input logic [15:0] im, input logic mux, input int wr, input int ps,
                                input logic wb, input logic mwe, input logic [15:0] pcn, input int lat);
        vec_t v;
        v.ir = ir; v.z = z; v.dsrc = dsrc; v.fWait = fWait; v.mWait = mWait;
        v.isMem = isMem; v.isAlu = isAlu; v.eRDst = rd; v.eRSrc = rs; v.eAluOp = op;
        v.eImm = im; v.eMux = mux; v.eWrites = wr; v.ePsr = ps; v.eWb = wb;
        v.eMemWe = mwe; v.ePcNext = pcn; v.eLat = lat;
        return v;
    endfunction

    // Plays memory for one instruction: serves the fetch, then any data
    // access, and stops at the next instruction fetch.
    task automatic runVec(input int idx, input vec_t v);
        vec_t        e;
        bit          fetchBad, memBad, done, memServed;
        logic        wbAtWr;
        int          writes, psrs, wrCyc, lat, mw;
        logic [3:0]  gRDst, gRSrc;
        logic [4:0]  gAluOp;
        logic [15:0] gImm;
        logic        gMux;
        string       p;
        p = $sformatf("v%0d", idx);
        fetchBad = 0; memBad = 0; done = 0; memServed = 0; wbAtWr = 0;
        writes = 0; psrs = 0; wrCyc = -1; lat = -1; mw = 0;
        gRDst = '0; gRSrc = '0; gAluOp = '0; gImm = '0; gMux = 1'b0;
        dSrc  = v.dsrc;
        dDst  = 16'hA5A5;
        psrIn = v.z ? 5'b00010 : 5'b11101;
        for (int w = 0; w <= v.fWait; w++) begin
            if (w > 0) @(negedge clk);
            mem_ack   = (w == v.fWait);
            mem_rdata = (w == v.fWait) ? v.ir : 16'hDEAD;
            #1;
            if (!mem_req || mem_we || mem_addr !== expPc || write || psr_we) fetchBad = 1;
        end
        sbq.push_back(v);
        for (int cyc = 1; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 16'hDEAD;
            #1;
            if (cyc == 1) begin
                gRDst = rDst; gRSrc = rSrc; gAluOp = aluOp; gImm = imm; gMux = IMM_MUX;
            end
            if (write) begin writes++; wrCyc = cyc; wbAtWr = wb_mem; end
            if (psr_we) psrs++;
            if (mem_req && v.isMem && !memServed) begin
                if (mem_addr !== v.dsrc || mem_we !== v.eMemWe) memBad = 1;
                if (mw == v.mWait) begin
                    mem_ack   = 1'b1;
                    mem_rdata = 16'h7777;
                    #1;
                    if (write) begin writes++; wrCyc = cyc; wbAtWr = wb_mem; end
                    if (psr_we) psrs++;
                    if (mem_addr !== v.dsrc || mem_we !== v.eMemWe) memBad = 1;
                    memServed = 1;
                end else begin
                    mw++;
                end
            end else if (mem_req) begin
                done = 1;
                lat  = cyc;
            end
        end
        e = sbq.pop_front();
        check({p, "_fetch"}, 32'(fetchBad), 32'd0);
        check({p, "_done"}, 32'(done), 32'd1);
        check({p, "_rdst"}, 32'(gRDst), 32'(e.eRDst));
        check({p, "_rsrc"}, 32'(gRSrc), 32'(e.eRSrc));
        if (e.isAlu) begin
            check({p, "_aluop"}, 32'(gAluOp), 32'(e.eAluOp));
            check({p, "_immmux"}, 32'(gMux), 32'(e.eMux));
            if (e.eMux) check({p, "_imm"}, 32'(gImm), 32'(e.eImm));
        end
        check({p, "_writes"}, 32'(writes), 32'(e.eWrites));
        check({p, "_psrwe"}, 32'(psrs), 32'(e.ePsr));
        if (e.eWrites > 0) begin
            check({p, "_wbmem"}, 32'(wbAtWr), 32'(e.eWb));
            check({p, "_wrcyc"}, 32'(wrCyc), 32'(e.eLat - 1));
        end
        if (e.isMem) begin
            check({p, "_memaccess"}, 32'(memBad), 32'd0);
            check({p, "_memserved"}, 32'(memServed), 32'd1);
        end
        check({p, "_latency"}, 32'(lat), 32'(e.eLat));
        check({p, "_pc"}, 32'(pc), 32'(e.ePcNext));
        check({p, "_fetchaddr"}, 32'(mem_addr), 32'(e.ePcNext));
        $display("[TB] instr %s ir=%h pc %h -> %h lat=%0d writes=%0d psr_we=%0d",
                 p, e.ir, expPc, pc, lat, writes, psrs);
        expPc = e.ePcNext;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int haltCnt, pcBad, strobeBad;
        //            ir       z     dsrc     fw mw mem alu rd    rs    aluOp      imm      mux wr ps wb    mwe   pcNext   lat
        vecs[0]  = mk(16'h5105, 1'b0, 16'h0BAD, 0, 0, 0, 1, 4'h1, 4'h5, ALUOp_ADD, 16'h0005, 1'b1, 1, 1, 1'b0, 1'b0, 16'h0001, 3);
        vecs[1]  = mk(16'hC0FE, 1'b1, 16'h0BAD, 1, 0, 0, 0, 4'h0, 4'hE, ALUOp_NOP, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0, 16'hFFFF, 3);
        vecs[2]  = mk(16'h0253, 1'b0, 16'h0BAD, 2, 0, 0, 1, 4'h2, 4'h3, ALUOp_ADD, 16'h0000, 1'b0, 1, 1, 1'b0, 1'b0, 16'h0000, 3);
        vecs[3]  = mk(16'hD2FB, 1'b1, 16'h0BAD, 0, 0, 0, 1, 4'h2, 4'hB, ALUOp_MOV, 16'h00FB, 1'b1, 1, 1, 1'b0, 1'b0, 16'h0001, 3);
        vecs[4]  = mk(16'hC0FE, 1'b0, 16'h0BAD, 0, 0, 0, 0, 4'h0, 4'hE, ALUOp_NOP, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0002, 3);
        vecs[5]  = mk(16'h53FB, 1'b0, 16'h0BAD, 0, 0, 0, 1, 4'h3, 4'hB, ALUOp_ADD, 16'hFFFB, 1'b1, 1, 1, 1'b0, 1'b0, 16'h0003, 3);
        vecs[6]  = mk(16'h4502, 1'b0, 16'h0040, 0, 3, 1, 0, 4'h5, 4'h2, ALUOp_NOP, 16'h0000, 1'b0, 1, 0, 1'b1, 1'b0, 16'h0004, 7);
        vecs[7]  = mk(16'h4643, 1'b1, 16'h1234, 0, 0, 1, 0, 4'h6, 4'h3, ALUOp_NOP, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b1, 16'h0005, 4);
        vecs[8]  = mk(16'h01B2, 1'b0, 16'h0BAD, 0, 0, 0, 1, 4'h1, 4'h2, ALUOp_CMP, 16'h0000, 1'b0, 0, 1, 1'b0, 1'b0, 16'h0006, 3);
        vecs[9]  = mk(16'h7123, 1'b1, 16'h0BAD, 0, 0, 0, 0, 4'h1, 4'h3, ALUOp_NOP, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0007, 3);
        vecs[10] = mk(16'h0F72, 1'b0, 16'h0BAD, 0, 0, 0, 0, 4'hF, 4'h2, ALUOp_NOP, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0008, 3);
        vecs[11] = mk(16'h4120, 1'b0, 16'h0BAD, 0, 0, 0, 0, 4'h1, 4'h0, ALUOp_NOP, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0009, 3);
        vecs[12] = mk(16'h0391, 1'b0, 16'h0BAD, 0, 0, 0, 1, 4'h3, 4'h1, ALUOp_SUB, 16'h0000, 1'b0, 1, 1, 1'b0, 1'b0, 16'h000A, 3);
        vecs[13] = mk(16'h0432, 1'b0, 16'h0BAD, 1, 0, 0, 1, 4'h4, 4'h2, ALUOp_XOR, 16'h0000, 1'b0, 1, 1, 1'b0, 1'b0, 16'h000B, 3);

        // Reset, with a stray ack present that must not raise anything
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hF000;
        dSrc = 16'h0000; dDst = 16'h0000; psrIn = 5'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_strobes", 32'({mem_req, mem_we, write, psr_we, wb_mem, IMM_MUX, halted}), 32'd0);
        check("reset_fields", 32'({rSrc, rDst, aluOp, imm}), 32'd0);
        $display("[TB] reset held: pc=%h mem_req=%b halted=%b", pc, mem_req, halted);
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b0;
        #1;
        check("first_fetch_req", 32'(mem_req), 32'd1);

        for (int i = 0; i < 14; i++) runVec(i, vecs[i]);

        // STOR interrupted by reset in its second wait cycle
        dSrc = 16'h0200; psrIn = 5'b0;
        mem_ack = 1'b1; mem_rdata = 16'h4643;
        #1;
        @(negedge clk); mem_ack = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("stor_wait1_req", 32'({mem_req, mem_we, mem_addr}), 32'({2'b11, 16'h0200}));
        @(negedge clk); reset = 1'b1; #1;
        @(negedge clk); mem_ack = 1'b1; #1;
        check("stor_rst_memreq", 32'(mem_req), 32'd0);
        check("stor_rst_pc", 32'(pc), 32'd0);
        check("stor_rst_write", 32'({write, wb_mem, mem_we}), 32'd0);
        @(negedge clk); reset = 1'b0; mem_ack = 1'b0; #1;
        check("stor_rst_refetch", 32'({mem_req, mem_we, mem_addr}), 32'({2'b10, 16'h0000}));
        $display("[TB] stor reset: pc=%h mem_req=%b mem_addr=%h", pc, mem_req, mem_addr);
        expPc = 16'h0000;
        runVec(14, vecs[0]);

        // HALT at pc=0x0001 with stray acks
        mem_ack = 1'b1; mem_rdata = 16'hF000; #1;
        @(negedge clk); mem_ack = 1'b0; #1;
        @(negedge clk); #1;
        check("halt_exec_halted", 32'(halted), 32'd0);
        haltCnt = 0; pcBad = 0; strobeBad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
            #1;
            if (halted) haltCnt++;
            if (pc !== 16'h0001) pcBad++;
            if (mem_req || mem_we || write || psr_we || wb_mem) strobeBad++;
        end
        check("halt_halted_cycles", 32'(haltCnt), 32'd20);
        check("halt_pc_frozen", 32'(pcBad), 32'd0);
        check("halt_strobes", 32'(strobeBad), 32'd0);
        $display("[TB] halt: halted=%b pc=%h over 20 cycles", halted, pc);
        @(negedge clk); reset = 1'b1; mem_ack = 1'b0;
        @(negedge clk); #1;
        check("halt_reset_cleared", 32'({halted, pc}), 32'd0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 mem_req  out  1  memory request; held high until mem_ack.
REQ-004 mem_we  out  1  write qualifier for mem_req; 1 means store.
REQ-005 mem_addr  out  16  memory word address; stable while mem_req=1.
REQ-006 mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle.
REQ-007 mem_rdata  in  16  fetched instruction or load data.
REQ-008 pc  out  16  program counter to the datapath.
REQ-009 rSrc, rDst  out  4 each  register-file selects for reg_alu.
REQ-010 aluOp  out  5  ALU operation code, using the shared ALUOp_* encodings.
REQ-011 imm  out  16  extended immediate.
REQ-012 IMM_MUX  out  1  selects imm (1) or dSrc (0) as the ALU B operand.
REQ-013 write  out  1  register-file write strobe; one cycle per instruction.
REQ-014 wb_mem  out  1  selects mem_data (1) or ALU result (0) for writeback.
REQ-015 psr_we  out  1  PSR update strobe.
REQ-016 dSrc, dDst  in  16 each  register read data, used for load/store address and store data.
REQ-017 psrIn  in  5  current flags {C,L,F,Z,N}; branches use only Z.
REQ-018 halted  out  1  high once a HALT instruction has been executed.

Function
REQ-019 The FSM SHALL have states FETCH, DECODE, EXEC, MEM and HALT, encoded in the shared package.
REQ-020 FETCH SHALL drive mem_req=1, mem_we=0 and mem_addr=pc, latch mem_rdata into IR on mem_ack, then go to DECODE.
REQ-021 DECODE SHALL last one cycle and SHALL drive rDst=IR[11:8], rSrc=IR[3:0], aluOp, imm and IMM_MUX from IR.
REQ-022 Opcode IR[15:12] 0x0 (R-type) SHALL take aluOp from IR[7:4] via the package table: ADD, SUB, AND, OR, XOR, MOV, CMP.
REQ-023 Opcode 0x5 (ADDI) SHALL set IMM_MUX=1 and imm = sign-extended IR[7:0].
REQ-024 Opcode 0xD (MOVI) SHALL set IMM_MUX=1 and imm = zero-extended IR[7:0].
REQ-025 Opcode 0x4 SHALL decode IR[7:4]: 0x0 is LOAD (rDst <= mem[dSrc]) and 0x4 is STOR (mem[dSrc] <= dDst).
REQ-026 Opcode 0xC (BEQ) SHALL branch if Z=1 and SHALL use displacement = sign-extended IR[7:0].
REQ-027 Opcode 0xF SHALL be HALT.
REQ-028 Any other opcode or opext SHALL execute as a NOP (pc+1, no strobes).
REQ-029 In EXEC, ALU ops SHALL pulse write=1 and psr_we=1 for one cycle; CMP SHALL pulse psr_we only; then pc <= pc+1 and go to FETCH.
REQ-030 In EXEC, LOAD and STOR SHALL go to MEM.
REQ-031 In EXEC, BEQ SHALL set pc <= pc+disp if taken, else pc+1, with no strobes, then go to FETCH.
REQ-032 In EXEC, HALT SHALL go to the HALT state.
REQ-033 MEM SHALL drive mem_req=1, mem_addr=dSrc and mem_we=(STOR) until mem_ack.
REQ-034 On mem_ack for LOAD, MEM SHALL pulse write=1 with wb_mem=1.
REQ-035 On mem_ack for either LOAD or STOR, MEM SHALL set pc <= pc+1 and go to FETCH.
REQ-036 mem_ack received in the first cycle of mem_req SHALL be accepted; minimum latency is 3 cycles for ALU/branch instructions and 4 cycles for load/store.
REQ-037 mem_ack received while mem_req=0 SHALL be ignored.
REQ-038 PC arithmetic SHALL be modulo 2^16 (0xFFFF+1 = 0x0000; a backward displacement below 0 wraps).
REQ-039 HALT SHALL hold pc, keep all strobes at 0, set halted=1, and be left only by reset.
REQ-040 write, psr_we, mem_req and mem_we SHALL never be asserted in FETCH except mem_req/mem_addr as specified above.

Reset
REQ-041 While reset=1, the block SHALL force state=FETCH, pc=0x0000 and IR=0x0000.
REQ-042 While reset=1, write, psr_we, mem_req, mem_we, wb_mem, IMM_MUX and halted SHALL be 0, and rSrc, rDst, aluOp, imm SHALL be 0.
REQ-043 Reset asserted during a pending FETCH or MEM SHALL drop mem_req at the next edge and discard the in-flight access, with no write.
REQ-044 The first fetch SHALL occur in the cycle after reset deasserts.

Structure
REQ-045 Opcodes, opext codes, ALUOp_* values and state encodings SHALL live in the shared defines package.
REQ-046 Combinational decode (IR to aluOp, imm, IMM_MUX, instruction class) SHALL be the sub-module cpu_decode; the FSM and PC remain in cpu_ctrl.

Verification
REQ-047 Reset, then mem returns 0x5105 (ADDI r1,5) with 0-wait ack -> write pulses in cycle 3 with rDst=1, IMM_MUX=1, imm=0x0005, aluOp=ALUOp_ADD; pc becomes 0x0001.
REQ-048 ADDI with IR[7:0]=0xFB -> imm=0xFFFB.
REQ-049 MOVI 0xD2FB -> imm=0x00FB.
REQ-050 LOAD with dSrc=0x0040 and ack delayed 3 cycles -> mem_addr=0x0040 stable while mem_req=1, mem_we=0; write and wb_mem pulse together with the ack cycle.
REQ-051 BEQ 0xC0FE at pc=0x0001: with Z=1 -> pc=0xFFFF; with Z=0 -> pc=0x0002; write and psr_we stay 0.
REQ-052 Reset asserted in the second wait cycle of a STOR -> mem_req=0 next cycle, pc=0x0000, no write.
REQ-053 HALT 0xF000 -> halted=1 and pc frozen for 20 cycles, with stray mem_ack ignored.
REQ-054 Opcode 0x7 -> NOP, pc+1, no strobes.
